// File: rtl/nbcac_rx_gearbox_22to32_if.sv
// rtl/nbcac_rx_gearbox_22to32_if.sv - decoded-word input and packed-word output handshakes of the rx gearbox
interface nbcac_rx_gearbox_22to32_if #(
    parameter int IN_W  = 22,
    parameter int OUT_W = 32,
    parameter int OF_W  = $clog2(OUT_W) + 1
) ();
    logic              in_valid;
    logic [IN_W-1:0]   in_data;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic [OF_W-1:0]   out_fill;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_fill
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_fill
    );
endinterface

// File: rtl/nbcac_rx_gearbox_22to32.sv
// rtl/nbcac_rx_gearbox_22to32.sv - packs 22-bit decoded words LSB-first into 32-bit output words
module nbcac_rx_gearbox_22to32 #(
    parameter int IN_W   = 22,
    parameter int OUT_W  = 32,
    parameter int ACC_W  = 64,
    parameter int FILL_W = 7
) (
    input  logic clock,
    input  logic rst_n,
    input  logic flush,
    output logic overflow_err,
    nbcac_rx_gearbox_22to32_if.slave bus
);
    localparam int OF_W = $clog2(OUT_W) + 1;
    localparam logic [FILL_W-1:0] OUT_F  = FILL_W'(OUT_W);
    localparam logic [FILL_W-1:0] IN_F   = FILL_W'(IN_W);
    localparam logic [FILL_W-1:0] ROOM_F = FILL_W'(ACC_W - IN_W);

    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_nx;
    logic [ACC_W-1:0]  base;
    logic [ACC_W-1:0]  in_ext;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_nx;
    logic [FILL_W-1:0] base_fill;
    logic [OUT_W-1:0]  part_mask;
    logic              flush_pend;
    logic              slot_free;
    logic              emit_full;
    logic              emit_part;
    logic              accept;

    assign bus.in_ready = (fill <= ROOM_F) && !flush_pend;
    assign accept       = bus.in_valid && bus.in_ready;
    assign slot_free    = !bus.out_valid || bus.out_ready;
    assign emit_full    = slot_free && (fill >= OUT_F);
    assign emit_part    = slot_free && flush_pend && (fill != '0) && (fill < OUT_F);
    assign in_ext       = ACC_W'(bus.in_data);

    // Retire the outgoing word first, then append any accepted word above what remains.
    always_comb begin
        base      = acc;
        base_fill = fill;
        if (emit_full) begin
            base      = acc >> OUT_W;
            base_fill = fill - OUT_F;
        end else if (emit_part) begin
            base      = '0;
            base_fill = '0;
        end
        acc_nx  = base;
        fill_nx = base_fill;
        if (accept) begin
            acc_nx  = base | (in_ext << base_fill);
            fill_nx = base_fill + IN_F;
        end
        for (int i = 0; i < OUT_W; i++) begin
            part_mask[i] = (FILL_W'(i) < fill);
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            acc           <= '0;
            fill          <= '0;
            flush_pend    <= 1'b0;
            overflow_err  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_fill  <= '0;
        end else begin
            acc  <= acc_nx;
            fill <= fill_nx;

            if (bus.in_valid && !bus.in_ready) begin
                overflow_err <= 1'b1;
            end

            // Full words keep draining while pending; the flag drops on the partial word or once empty.
            if (flush) begin
                flush_pend <= 1'b1;
            end else if (flush_pend && slot_free && (emit_part || fill == '0)) begin
                flush_pend <= 1'b0;
            end

            if (emit_full) begin
                bus.out_data  <= acc[OUT_W-1:0];
                bus.out_fill  <= OF_W'(OUT_W);
                bus.out_valid <= 1'b1;
            end else if (emit_part) begin
                bus.out_data  <= acc[OUT_W-1:0] & part_mask;
                bus.out_fill  <= fill[OF_W-1:0];
                bus.out_valid <= 1'b1;
            end else if (slot_free) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_nbcac_rx_gearbox_22to32.sv
// tb/tb_nbcac_rx_gearbox_22to32.sv - randomized and directed bench for the 22-to-32 rx gearbox
module tb_nbcac_rx_gearbox_22to32;
    logic clock = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic overflow_err;

    nbcac_rx_gearbox_22to32_if bus ();

    nbcac_rx_gearbox_22to32 dut (
        .clock        (clock),
        .rst_n        (rst_n),
        .flush        (flush),
        .overflow_err (overflow_err),
        .bus          (bus.slave)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    bit acc_seen;

    // Reference: a plain bit FIFO of every accepted bit, oldest first.
    logic        q[$];
    logic [31:0] got_data[$];
    logic [5:0]  got_fill[$];

    function automatic logic [31:0] model_word(int n);
        logic [31:0] w = '0;
        for (int i = 0; i < n; i++) begin
            if (q.size() > 0) w[i] = q.pop_front();
            else              w[i] = 1'bx;
        end
        return w;
    endfunction

    task automatic cycle();
        acc_seen = 1'b0;
        if (rst_n) begin
            if (bus.in_valid && bus.in_ready) begin
                for (int i = 0; i < 22; i++) q.push_back(bus.in_data[i]);
                acc_seen = 1'b1;
            end
            if (bus.out_valid && bus.out_ready) begin
                got_data.push_back(bus.out_data);
                got_fill.push_back(bus.out_fill);
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        rst_n = 1'b1;
        q.delete();
        got_data.delete();
        got_fill.delete();
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 22'($urandom);
        bus.out_ready = 1'b1;
        flush         = 1'b1;
        repeat (3) cycle();
        checks++;
        if ({bus.out_valid, bus.out_data, bus.out_fill, overflow_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b data=%h fill=%0d ovf=%b expected all zero",
                     bus.out_valid, bus.out_data, bus.out_fill, overflow_err);
        end
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        flush        = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: in_ready=%b expected 1", bus.in_ready);
        end
        repeat (4) cycle();
        checks++;
        if (got_data.size() != 0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_nothing_accepted: words=%0d out_valid=%b in_ready=%b expected 0,0,1",
                     got_data.size(), bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_stream();
        int i = 0;
        int budget = 0;
        logic [31:0] d, exp;
        logic [5:0]  f;
        apply_reset();
        bus.out_ready = 1'b1;
        while (i < 16 && budget < 100) begin
            bus.in_valid = bus.in_ready;
            bus.in_data  = 22'(i * 32'h01111);
            cycle();
            if (acc_seen) i++;
            budget++;
        end
        bus.in_valid = 1'b0;
        repeat (6) cycle();
        checks++;
        if (i != 16 || got_data.size() != 11) begin
            errors++;
            $display("FAIL stream_count: accepted=%0d words=%0d expected 16 and 11", i, got_data.size());
        end
        while (got_data.size() > 0) begin
            d   = got_data.pop_front();
            f   = got_fill.pop_front();
            exp = model_word(32);
            checks++;
            if (d !== exp || f !== 6'd32) begin
                errors++;
                $display("FAIL stream_word: data=%h fill=%0d expected data=%h fill=32", d, f, exp);
            end
        end
        checks++;
        if (q.size() != 0 || overflow_err !== 1'b0) begin
            errors++;
            $display("FAIL stream_residue: leftover_bits=%0d ovf=%b expected 0 and 0", q.size(), overflow_err);
        end
    endtask

    task automatic test_backpressure(input bit drop);
        bit          exp_rdy[6] = '{1, 1, 0, 1, 1, 0};
        logic [21:0] w[4];
        logic [31:0] first, d, exp;
        logic [5:0]  f;
        int          n = 0;
        apply_reset();
        for (int k = 0; k < 4; k++) w[k] = 22'($urandom);
        first = 32'(w[0]) | (32'(w[1][9:0]) << 22);
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (bus.in_ready !== exp_rdy[k]) begin
                errors++;
                $display("FAIL bp_in_ready[%0d]: in_ready=%b expected %b", k, bus.in_ready, exp_rdy[k]);
            end
            if (k >= 3) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== first || bus.out_fill !== 6'd32) begin
                    errors++;
                    $display("FAIL bp_hold[%0d]: valid=%b data=%h fill=%0d expected 1 %h 32",
                             k, bus.out_valid, bus.out_data, bus.out_fill, first);
                end
            end
            if (exp_rdy[k]) begin
                bus.in_valid = 1'b1;
                bus.in_data  = w[n];
                n++;
            end else begin
                bus.in_valid = drop;
                bus.in_data  = 22'($urandom);
            end
            cycle();
        end
        bus.in_valid = 1'b0;
        checks++;
        if (overflow_err !== drop) begin
            errors++;
            $display("FAIL bp_overflow: ovf=%b expected %b", overflow_err, drop);
        end
        bus.out_ready = 1'b1;
        repeat (4) cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        repeat (3) cycle();
        checks++;
        if (got_data.size() != 3) begin
            errors++;
            $display("FAIL bp_count: words=%0d expected 3", got_data.size());
        end
        for (int k = 0; got_data.size() > 0; k++) begin
            d   = got_data.pop_front();
            f   = got_fill.pop_front();
            exp = model_word(k < 2 ? 32 : 24);
            checks++;
            if (d !== exp || f !== (k < 2 ? 6'd32 : 6'd24)) begin
                errors++;
                $display("FAIL bp_word[%0d]: data=%h fill=%0d expected data=%h", k, d, f, exp);
            end
        end
        checks++;
        if (q.size() != 0 || overflow_err !== drop) begin
            errors++;
            $display("FAIL bp_end: leftover_bits=%0d ovf=%b expected 0 and %b", q.size(), overflow_err, drop);
        end
    endtask

    task automatic test_flush_partial();
        logic [21:0] d;
        apply_reset();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 22'h2AAAAA;
        cycle();
        bus.in_valid = 1'b0;
        flush        = 1'b1;
        cycle();
        flush = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_pending: in_ready=%b out_valid=%b expected 0 0", bus.in_ready, bus.out_valid);
        end
        cycle();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h002AAAAA || bus.out_fill !== 6'd22 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_word: valid=%b data=%h fill=%0d in_ready=%b expected 1 002aaaaa 22 1",
                     bus.out_valid, bus.out_data, bus.out_fill, bus.in_ready);
        end
        cycle();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_single: out_valid=%b expected 0", bus.out_valid);
        end
        q.delete();
        got_data.delete();
        got_fill.delete();
        d            = 22'($urandom);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        flush        = 1'b1;
        cycle();
        bus.in_valid = 1'b0;
        flush        = 1'b0;
        repeat (3) cycle();
        checks++;
        if (got_data.size() != 1 || got_data[0] !== 32'(d) || got_fill[0] !== 6'd22) begin
            errors++;
            $display("FAIL flush_same_cycle: words=%0d data=%h expected 1 word %h fill 22",
                     got_data.size(), got_data.size() > 0 ? got_data[0] : 32'h0, 32'(d));
        end
    endtask

    task automatic test_flush_empty();
        apply_reset();
        bus.out_ready = 1'b1;
        flush         = 1'b1;
        cycle();
        flush = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_empty_pend: in_ready=%b out_valid=%b expected 0 0", bus.in_ready, bus.out_valid);
        end
        cycle();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_empty_done: in_ready=%b out_valid=%b expected 1 0", bus.in_ready, bus.out_valid);
        end
        repeat (2) cycle();
        checks++;
        if (got_data.size() != 0) begin
            errors++;
            $display("FAIL flush_empty_words: words=%0d expected 0", got_data.size());
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            bus.in_valid = bus.in_ready;
            bus.in_data  = 22'($urandom);
            cycle();
        end
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_pre: out_valid=%b in_ready=%b expected 1 1", bus.out_valid, bus.in_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.out_fill !== 6'd0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: valid=%b data=%h fill=%0d in_ready=%b expected 0 0 0 1",
                     bus.out_valid, bus.out_data, bus.out_fill, bus.in_ready);
        end
        @(posedge clock);
        #1;
        rst_n = 1'b1;
        q.delete();
        got_data.delete();
        got_fill.delete();
        bus.out_ready = 1'b1;
        flush         = 1'b1;
        cycle();
        flush = 1'b0;
        repeat (3) cycle();
        checks++;
        if (got_data.size() != 0) begin
            errors++;
            $display("FAIL async_discard: words=%0d expected 0", got_data.size());
        end
    endtask

    task automatic test_random();
        logic [31:0] d, exp;
        logic [5:0]  f;
        apply_reset();
        for (int c = 0; c < 620; c++) begin
            if (c < 600) begin
                bus.in_valid  = ($urandom % 4) != 0;
                bus.in_data   = 22'($urandom);
                bus.out_ready = ($urandom % 3) != 0;
                flush         = ($urandom % 40) == 0;
            end else begin
                bus.in_valid  = 1'b0;
                bus.out_ready = 1'b1;
                flush         = (c == 610);
            end
            cycle();
            while (got_data.size() > 0) begin
                d   = got_data.pop_front();
                f   = got_fill.pop_front();
                exp = model_word(int'(f));
                checks++;
                if (f == 6'd0 || f > 6'd32 || d !== exp) begin
                    errors++;
                    $display("FAIL random_word: data=%h fill=%0d expected data=%h", d, f, exp);
                end
            end
        end
        checks++;
        if (q.size() != 0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL random_drain: leftover_bits=%0d out_valid=%b expected 0 0", q.size(), bus.out_valid);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #1;
        test_reset();
        test_stream();
        test_backpressure(1'b0);
        test_backpressure(1'b1);
        test_flush_partial();
        test_flush_empty();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
